comp_fill_unit: RTL and testbench

COMP_FILL_UNIT -- requirements
Module: comp_fill_unit

---
 rtl/comp_fill_unit.sv | 199 +++++++++++++++++++
 tb/tb_comp_fill_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_fill_unit.sv
// comp_fill_unit
//   Two-stage dictionary-compression fill pipeline between memory and a
//   compressed instruction cache. Each 32-bit word is split into three
//   fields. Stage 1 holds the word and presents the field values to three
//   external dictionaries. Stage 2 registers the dictionary keys and marks
//   the word compressible when all three fields hit. The unit also tracks
//   line position, per-line compressibility and word statistics.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   in_valid/in_ready            memory word handshake
//   in_addr, in_rdata            word address / raw instruction word
//   fieldN_val_lookup            field N value to dictionary N (0 when S1 empty)
//   fieldN_val_lookup_res        dictionary N hit
//   fieldN_key_found             dictionary N key on hit
//   out_valid/out_ready          result handshake toward compressed cache
//   out_addr, out_raw            address / original word of result
//   out_key                      {key3, key2, key1}, zero unless out_comp
//   out_comp                     all three fields hit
//   out_last                     result is the last word of its line
//   line_comp                    whole line compressible (valid with out_last)
//   comp_cnt, raw_cnt            saturating compressed / raw word counters
module comp_fill_unit #(
  parameter int unsigned F1_VAL_W   = 7,
  parameter int unsigned F2_VAL_W   = 15,
  parameter int unsigned F3_VAL_W   = 10,
  parameter int unsigned F1_KEY_W   = 3,
  parameter int unsigned F2_KEY_W   = 8,
  parameter int unsigned F3_KEY_W   = 5,
  parameter int unsigned BLOCK_SIZE = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [31:0]                          in_addr,
  input  logic [31:0]                          in_rdata,
  output logic [F1_VAL_W-1:0]                  field1_val_lookup,
  input  logic                                 field1_val_lookup_res,
  input  logic [F1_KEY_W-1:0]                  field1_key_found,
  output logic [F2_VAL_W-1:0]                  field2_val_lookup,
  input  logic                                 field2_val_lookup_res,
  input  logic [F2_KEY_W-1:0]                  field2_key_found,
  output logic [F3_VAL_W-1:0]                  field3_val_lookup,
  input  logic                                 field3_val_lookup_res,
  input  logic [F3_KEY_W-1:0]                  field3_key_found,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [31:0]                          out_addr,
  output logic [F1_KEY_W+F2_KEY_W+F3_KEY_W-1:0] out_key,
  output logic [31:0]                          out_raw,
  output logic                                 out_comp,
  output logic                                 out_last,
  output logic                                 line_comp,
  output logic [15:0]                          comp_cnt,
  output logic [15:0]                          raw_cnt
);

  localparam int unsigned KEY_W = F1_KEY_W + F2_KEY_W + F3_KEY_W;
  localparam int unsigned F2_LO = F1_VAL_W;
  localparam int unsigned F3_LO = F1_VAL_W + F2_VAL_W;
  localparam int unsigned CNT_W = (BLOCK_SIZE > 2) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_SIZE - 1);

  // Stage 1
  logic              s1_valid_q, s1_valid_d;
  logic [31:0]       s1_addr_q,  s1_addr_d;
  logic [31:0]       s1_word_q,  s1_word_d;

  // Stage 2
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_addr_q,  out_addr_d;
  logic [31:0]       out_raw_q,   out_raw_d;
  logic              out_comp_q,  out_comp_d;
  logic [KEY_W-1:0]  out_key_q,   out_key_d;

  // Line tracking and statistics
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic              acc_q,  acc_d;
  logic [15:0]       comp_cnt_q, comp_cnt_d;
  logic [15:0]       raw_cnt_q,  raw_cnt_d;

  logic s1_adv;
  logic in_acc;
  logic out_hs;
  logic hit_all;
  logic last_w;

  always_comb begin
    s1_adv  = s1_valid_q & (~out_valid_q | out_ready);
    in_ready = ~reset & (~s1_valid_q | s1_adv);
    in_acc  = in_valid & in_ready;
    out_hs  = out_valid_q & out_ready;
    hit_all = field1_val_lookup_res & field2_val_lookup_res & field3_val_lookup_res;
    last_w  = out_valid_q & (wcnt_q == LAST_IDX);
  end

  always_comb begin
    field1_val_lookup = '0;
    field2_val_lookup = '0;
    field3_val_lookup = '0;
    if (s1_valid_q) begin
      field1_val_lookup = s1_word_q[F1_VAL_W-1:0];
      field2_val_lookup = s1_word_q[F2_LO +: F2_VAL_W];
      field3_val_lookup = s1_word_q[F3_LO +: F3_VAL_W];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_addr_d  = s1_addr_q;
    s1_word_d  = s1_word_q;
    // An accept refills S1 even when it advances in the same cycle.
    if (in_acc) begin
      s1_valid_d = 1'b1;
      s1_addr_d  = in_addr;
      s1_word_d  = in_rdata;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_raw_d   = out_raw_q;
    out_comp_d  = out_comp_q;
    out_key_d   = out_key_q;
    if (s1_adv) begin
      out_valid_d = 1'b1;
      out_addr_d  = s1_addr_q;
      out_raw_d   = s1_word_q;
      out_comp_d  = hit_all;
      out_key_d   = hit_all ? {field3_key_found, field2_key_found, field1_key_found} : '0;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    wcnt_d     = wcnt_q;
    acc_d      = acc_q;
    comp_cnt_d = comp_cnt_q;
    raw_cnt_d  = raw_cnt_q;
    if (out_hs) begin
      wcnt_d = wcnt_q + CNT_W'(1);
      acc_d  = last_w ? 1'b1 : (acc_q & out_comp_q);
      if (out_comp_q) begin
        if (comp_cnt_q != '1) comp_cnt_d = comp_cnt_q + 16'd1;
      end else begin
        if (raw_cnt_q != '1) raw_cnt_d = raw_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_word_q   <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_raw_q   <= '0;
      out_comp_q  <= 1'b0;
      out_key_q   <= '0;
      wcnt_q      <= '0;
      acc_q       <= 1'b1;
      comp_cnt_q  <= '0;
      raw_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      s1_word_q   <= s1_word_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_raw_q   <= out_raw_d;
      out_comp_q  <= out_comp_d;
      out_key_q   <= out_key_d;
      wcnt_q      <= wcnt_d;
      acc_q       <= acc_d;
      comp_cnt_q  <= comp_cnt_d;
      raw_cnt_q   <= raw_cnt_d;
    end
  end

  always_comb begin
    out_valid = out_valid_q;
    out_addr  = out_addr_q;
    out_raw   = out_raw_q;
    out_comp  = out_comp_q;
    out_key   = out_key_q;
    out_last  = last_w;
    // Accumulator holds the AND of earlier words; fold in the current one.
    line_comp = acc_q & out_comp_q;
    comp_cnt  = comp_cnt_q;
    raw_cnt   = raw_cnt_q;
  end

endmodule

// File: tb/tb_comp_fill_unit.sv
module tb_comp_fill_unit;

  localparam int unsigned BS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_rdata;
  logic [6:0]  f1_lk;
  logic        f1_res;
  logic [2:0]  f1_key;
  logic [14:0] f2_lk;
  logic        f2_res;
  logic [7:0]  f2_key;
  logic [9:0]  f3_lk;
  logic        f3_res;
  logic [4:0]  f3_key;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [15:0] out_key;
  logic [31:0] out_raw;
  logic        out_comp;
  logic        out_last;
  logic        line_comp;
  logic [15:0] comp_cnt;
  logic [15:0] raw_cnt;

  always #5 clk = ~clk;

  comp_fill_unit #(
    .F1_VAL_W(7), .F2_VAL_W(15), .F3_VAL_W(10),
    .F1_KEY_W(3), .F2_KEY_W(8), .F3_KEY_W(5),
    .BLOCK_SIZE(BS)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_rdata(in_rdata),
    .field1_val_lookup(f1_lk), .field1_val_lookup_res(f1_res), .field1_key_found(f1_key),
    .field2_val_lookup(f2_lk), .field2_val_lookup_res(f2_res), .field2_key_found(f2_key),
    .field3_val_lookup(f3_lk), .field3_val_lookup_res(f3_res), .field3_key_found(f3_key),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_key(out_key), .out_raw(out_raw),
    .out_comp(out_comp), .out_last(out_last), .line_comp(line_comp),
    .comp_cnt(comp_cnt), .raw_cnt(raw_cnt)
  );

  // Dictionary stub: one entry per field.
  always_comb begin
    f1_res = (f1_lk == 7'h02);
    f1_key = f1_res ? 3'd1 : 3'd0;
    f2_res = (f2_lk == 15'h0044);
    f2_key = f2_res ? 8'd2 : 8'd0;
    f3_res = (f3_lk == 10'h000);
    f3_key = 5'd0;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } item_t;

  item_t pend_q[$];   // words waiting to be offered
  item_t exp_q[$];    // accepted words, in order, awaiting output
  int unsigned m_idx;
  bit          m_line_ok;
  int unsigned m_comp, m_raw;
  bit          obs_in_ready;

  // Reference: compressible iff every field matches its dictionary entry.
  function automatic bit ref_comp(input logic [31:0] w);
    return (w[6:0] == 7'h02) && (w[21:7] == 15'h0044) && (w[31:22] == 10'h000);
  endfunction

  function automatic logic [15:0] ref_key(input logic [31:0] w);
    // key3=0, key2=2, key1=1 packed as {key3[4:0], key2[7:0], key1[2:0]}
    return ref_comp(w) ? ((16'd0 << 11) | (16'd2 << 3) | 16'd1) : 16'h0000;
  endfunction

  task automatic cycle(input bit v_en, input bit rdy);
    item_t e;
    bit ihs, ohs, c;
    in_valid = v_en && (pend_q.size() > 0);
    if (pend_q.size() > 0) begin
      in_addr  = pend_q[0].addr;
      in_rdata = pend_q[0].word;
    end
    out_ready = rdy;
    @(negedge clk);
    obs_in_ready = in_ready;
    ihs = in_valid && in_ready;
    ohs = out_valid && out_ready;
    check_eq("comp_cnt", comp_cnt, m_comp);
    check_eq("raw_cnt", raw_cnt, m_raw);
    if (exp_q.size() == 0) check_eq("out_valid_idle", out_valid, 0);
    if (ohs && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = ref_comp(e.word);
      check_eq("out_addr", out_addr, e.addr);
      check_eq("out_raw", out_raw, e.word);
      check_eq("out_comp", out_comp, c);
      check_eq("out_key", out_key, ref_key(e.word));
      check_eq("out_last", out_last, m_idx == BS - 1);
      if (m_idx == BS - 1) check_eq("line_comp", line_comp, m_line_ok && c);
      m_line_ok = (m_idx == BS - 1) ? 1'b1 : (m_line_ok && c);
      m_idx = (m_idx + 1) % BS;
      if (c) begin
        if (m_comp < 65535) m_comp++;
      end else begin
        if (m_raw < 65535) m_raw++;
      end
    end
    if (ihs) exp_q.push_back(pend_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && n < 200) begin
      cycle(1, 1);
      n++;
    end
    check_eq("drain_done", exp_q.size() + pend_q.size(), 0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_key", out_key, 0);
    check_eq("rst_out_raw", out_raw, 0);
    check_eq("rst_out_addr", out_addr, 0);
    check_eq("rst_out_comp", out_comp, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_comp_cnt", comp_cnt, 0);
    check_eq("rst_raw_cnt", raw_cnt, 0);
    check_eq("rst_lookup1", f1_lk, 0);
    reset = 1'b0;
    pend_q.delete();
    exp_q.delete();
    m_idx = 0;
    m_line_ok = 1'b1;
    m_comp = 0;
    m_raw = 0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) < 8) w[6:0]   = 7'h02;
    if ($urandom_range(0, 9) < 8) w[21:7]  = 15'h0044;
    if ($urandom_range(0, 9) < 8) w[31:22] = 10'h000;
    return w;
  endfunction

  initial begin
    item_t it;
    int unsigned n;
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_rdata = '0; out_ready = 1'b0;
    do_reset();

    // Single compressible word: S1 after first edge, S2 after the next.
    pend_q.push_back('{addr: 32'h100, word: 32'h00002202});
    cycle(1, 1);
    check_eq("s1_lookup1", f1_lk, 32'h02);
    check_eq("s1_lookup2", f2_lk, 32'h44);
    check_eq("s1_lookup3", f3_lk, 32'h0);
    check_eq("lat_not_yet", out_valid, 0);
    cycle(1, 1);
    check_eq("lat_valid", out_valid, 1);
    check_eq("lat_comp", out_comp, 1);
    check_eq("lat_key", out_key, 32'h0011);
    drain();
    check_eq("single_comp_cnt", comp_cnt, 1);

    // Incompressible word.
    pend_q.push_back('{addr: 32'h104, word: 32'hFFFFFFFF});
    drain();
    check_eq("raw_word_cnt", raw_cnt, 1);

    // Full-throughput compressible line.
    do_reset();
    for (int i = 0; i < 4; i++) pend_q.push_back('{addr: 32'h200 + 4*i, word: 32'h00002202});
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1);
      check_eq("thru_in_ready", obs_in_ready, 1);
    end
    drain();

    // Mixed line, then a fully compressible line.
    for (int i = 0; i < 3; i++) pend_q.push_back('{addr: 32'h300 + 4*i, word: 32'h00002202});
    pend_q.push_back('{addr: 32'h30C, word: 32'hFFFFFFFF});
    for (int i = 0; i < 4; i++) pend_q.push_back('{addr: 32'h400 + 4*i, word: 32'h00002202});
    drain();

    // Backpressure: two words buffered, third stalled, S2 held.
    do_reset();
    pend_q.push_back('{addr: 32'h500, word: 32'h00002202});
    pend_q.push_back('{addr: 32'h504, word: 32'hFFFFFFFF});
    pend_q.push_back('{addr: 32'h508, word: 32'h12345678});
    cycle(1, 0);
    check_eq("bp_rdy0", obs_in_ready, 1);
    cycle(1, 0);
    check_eq("bp_rdy1", obs_in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0);
      check_eq("bp_in_ready", obs_in_ready, 0);
      check_eq("bp_hold_valid", out_valid, 1);
      check_eq("bp_hold_raw", out_raw, 32'h00002202);
      check_eq("bp_hold_addr", out_addr, 32'h500);
    end
    drain();

    // Reset mid-line discards the partial line and any in-flight word.
    do_reset();
    pend_q.push_back('{addr: 32'h600, word: 32'h00002202});
    pend_q.push_back('{addr: 32'h604, word: 32'h00002202});
    drain();
    pend_q.push_back('{addr: 32'h608, word: 32'h00002202});
    cycle(1, 1);
    do_reset();
    for (int i = 0; i < 4; i++) pend_q.push_back('{addr: 32'h700 + 4*i, word: 32'h00002202});
    drain();

    // Randomized traffic with random valid/ready.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      it.addr = $urandom;
      it.word = rand_word();
      pend_q.push_back(it);
    end
    n = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && n < 5000) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      n++;
    end
    check_eq("rand_done", exp_q.size() + pend_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
